// File: rtl/pipo_writer_pkg.sv
// Shared types and defaults for the pipo write-side controller.
// State encodings match the ones used by the pipo latch benches.
package pipo_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_SETUP = 1;
  localparam int unsigned DEF_PULSE = 1;
  localparam int unsigned DEF_HOLD  = 1;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter width; it only ever holds (count-1) of the longest phase.
  function automatic int unsigned cnt_width(input int unsigned s,
                                            input int unsigned p,
                                            input int unsigned h);
    return $clog2(max3(s, p, h) + 1);
  endfunction

endpackage

// File: rtl/pipo_writer_timer.sv
// Loadable down-counter shared by all timed phases of the write FSM.
module pipo_writer_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] value,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipo_writer.sv
// Write-side controller for the pipo latch: handshake in, timed data/le out.
// Optional PIPO_WRITER_SKIP_EN suppresses strobes that would rewrite the last word.
module pipo_writer
  import pipo_writer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SETUP = DEF_SETUP,
  parameter int unsigned PULSE = DEF_PULSE,
  parameter int unsigned HOLD  = DEF_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  input  logic             oe_en,
  output logic [WIDTH-1:0] data,
  output logic             le,
  output logic             oe_n,
  output logic             busy,
  output logic [WIDTH-1:0] last
);

  localparam int unsigned CW = cnt_width(SETUP, PULSE, HOLD);

  state_t        state, state_next;
  logic          load_c;
  logic [CW-1:0] load_val_c;
  logic          tmr_zero;
  logic          skip_c;
  logic          capture_c;
  logic          strobe_done_c;

`ifdef PIPO_WRITER_SKIP_EN
  logic last_vld;
  assign skip_c = last_vld && (in == last);
`else
  assign skip_c = 1'b0;
`endif

  pipo_writer_timer #(.CW(CW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (load_c),
    .value(load_val_c),
    .zero (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state; the timer is reloaded with (count-1) on every phase entry.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    load_val_c = '0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid && in_ready && !skip_c) begin
          state_next = ST_SETUP;
          load_c     = 1'b1;
          load_val_c = CW'(SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_next = ST_STROBE;
          load_c     = 1'b1;
          load_val_c = CW'(PULSE - 1);
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_next = ST_HOLD;
          load_c     = 1'b1;
          load_val_c = CW'(HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign capture_c     = (state == ST_IDLE) && (state_next == ST_SETUP);
  assign strobe_done_c = (state == ST_STROBE) && tmr_zero;

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= '0;
      le       <= 1'b0;
      oe_n     <= 1'b1;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      last     <= '0;
    end else begin
      if (capture_c) data <= in;
      le       <= (state_next == ST_STROBE);
      oe_n     <= ~oe_en;
      in_ready <= (state_next == ST_IDLE);
      busy     <= (state_next != ST_IDLE);
      if (strobe_done_c) last <= data;
    end
  end

`ifdef PIPO_WRITER_SKIP_EN
  always_ff @(posedge clk) begin
    if (rst)                last_vld <= 1'b0;
    else if (strobe_done_c) last_vld <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_pipo_writer.sv
// Self-checking bench for pipo_writer: default timing instance plus a
// SETUP=2/PULSE=3/HOLD=1 instance, with a scoreboard of strobed words.
module tb_pipo_writer;

  logic       clk;
  logic       rst;

  logic       a_in_valid, a_in_ready, a_oe_en, a_le, a_oe_n, a_busy;
  logic [7:0] a_in, a_data, a_last;
  logic       b_in_valid, b_in_ready, b_oe_en, b_le, b_oe_n, b_busy;
  logic [7:0] b_in, b_data, b_last;

  logic [7:0] latch_q;
  logic [7:0] pipo_out;

  int         tests = 0;
  int         fails = 0;
  int         pulse_cnt = 0;
  logic [7:0] exp_q[$];
  logic       a_le_q = 1'b0;

  pipo_writer u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in(a_in), .oe_en(a_oe_en), .data(a_data), .le(a_le), .oe_n(a_oe_n),
    .busy(a_busy), .last(a_last)
  );

  pipo_writer #(.WIDTH(8), .SETUP(2), .PULSE(3), .HOLD(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in(b_in), .oe_en(b_oe_en), .data(b_data), .le(b_le), .oe_n(b_oe_n),
    .busy(b_busy), .last(b_last)
  );

  // Behavioural pipo latch on instance A; a released bus reads as zero here.
  always_latch begin
    if (a_le) latch_q <= a_data;
  end
  assign pipo_out = a_oe_n ? 8'h00 : latch_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: each le rising edge on A must carry the next expected word.
  always @(negedge clk) begin
    if (a_le && !a_le_q) begin
      pulse_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard: unexpected le pulse, data=%h", a_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (a_data !== e) begin
          fails++;
          $display("FAIL scoreboard: strobed data=%h expected=%h", a_data, e);
        end
      end
    end
    a_le_q = a_le;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word on A and return just after the handshake edge (k=0).
  task automatic start_write_a(input logic [7:0] w, input bit expect_pulse);
    int n;
    n = 0;
    a_in       = w;
    a_in_valid = 1'b1;
    while (!a_in_ready && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (!a_in_ready) begin
      fails++;
      $display("FAIL handshake_timeout: in_ready=%b expected=1", a_in_ready);
      a_in_valid = 1'b0;
      return;
    end
    step();
    a_in_valid = 1'b0;
    if (expect_pulse) exp_q.push_back(w);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if (a_data !== 8'h00 || a_le !== 1'b0 || a_oe_n !== 1'b1 || a_busy !== 1'b0 ||
        a_last !== 8'h00 || a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: data=%h le=%b oe_n=%b busy=%b last=%h in_ready=%b expected 00 0 1 0 00 0",
               a_data, a_le, a_oe_n, a_busy, a_last, a_in_ready);
    end
    rst = 1'b0;
    step();
    tests++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: a_in_ready=%b b_in_ready=%b expected 1 1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_single_write();
    int le_start, le_len, rdy_at;
    le_start = -1; le_len = 0; rdy_at = -1;
    start_write_a(8'h55, 1'b1);
    tests++;
    if (a_data !== 8'h55 || a_busy !== 1'b1) begin
      fails++;
      $display("FAIL single_capture: data=%h busy=%b expected 55 1", a_data, a_busy);
    end
    for (int k = 0; k < 8; k++) begin
      if (a_le) begin
        if (le_start < 0) le_start = k;
        le_len++;
      end
      if (a_in_ready && rdy_at < 0) rdy_at = k;
      step();
    end
    tests++;
    if (le_start != 1 || le_len != 1) begin
      fails++;
      $display("FAIL single_le_timing: start=%0d len=%0d expected 1 1", le_start, le_len);
    end
    tests++;
    if (rdy_at != 3) begin
      fails++;
      $display("FAIL single_ready_back: k=%0d expected 3", rdy_at);
    end
    tests++;
    if (a_last !== 8'h55 || a_data !== 8'h55) begin
      fails++;
      $display("FAIL single_last: last=%h data=%h expected 55 55", a_last, a_data);
    end
    a_oe_en = 1'b1;
    step();
    tests++;
    if (a_oe_n !== 1'b0 || pipo_out !== 8'h55) begin
      fails++;
      $display("FAIL single_latch_out: oe_n=%b out=%h expected 0 55", a_oe_n, pipo_out);
    end
  endtask

  task automatic test_reset_mid_strobe();
    a_oe_en = 1'b1;
    start_write_a(8'h77, 1'b1);
    step();
    tests++;
    if (a_le !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre_strobe: le=%b expected 1", a_le);
    end
    rst = 1'b1;
    step();
    tests++;
    if (a_le !== 1'b0 || a_data !== 8'h00 || a_last !== 8'h00 || a_oe_n !== 1'b1 ||
        a_busy !== 1'b0 || a_in_ready !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_strobe: le=%b data=%h last=%h oe_n=%b busy=%b in_ready=%b expected 0 00 00 1 0 0",
               a_le, a_data, a_last, a_oe_n, a_busy, a_in_ready);
    end
    rst     = 1'b0;
    a_oe_en = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int  h1;
    bit  bad;
    h1  = -1;
    bad = 1'b0;
    start_write_a(8'h55, 1'b1);
    a_in       = 8'hAA;
    a_in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic hs;
      if (k <= 3 && a_data !== 8'h55) bad = 1'b1;
      hs = a_in_ready && a_in_valid;
      step();
      if (hs) begin
        h1 = k + 1;
        a_in_valid = 1'b0;
        exp_q.push_back(8'hAA);
      end
    end
    a_in_valid = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL b2b_data_hold: data left 55 before second handshake, data=%h expected 55", a_data);
    end
    tests++;
    if (h1 != 4) begin
      fails++;
      $display("FAIL b2b_spacing: second handshake at k=%0d expected 4", h1);
    end
    tests++;
    if (a_data !== 8'hAA || a_last !== 8'hAA) begin
      fails++;
      $display("FAIL b2b_final: data=%h last=%h expected AA AA", a_data, a_last);
    end
  endtask

  task automatic test_oe_toggle();
    a_oe_en = 1'b0;
    step();
    start_write_a(8'h3C, 1'b1);
    a_oe_en = 1'b1;
    tests++;
    if (a_oe_n !== 1'b1 || a_le !== 1'b0) begin
      fails++;
      $display("FAIL oe_k0: oe_n=%b le=%b expected 1 0", a_oe_n, a_le);
    end
    step();
    a_oe_en = 1'b0;
    tests++;
    if (a_oe_n !== 1'b0 || a_le !== 1'b1 || a_data !== 8'h3C) begin
      fails++;
      $display("FAIL oe_k1: oe_n=%b le=%b data=%h expected 0 1 3C", a_oe_n, a_le, a_data);
    end
    step();
    tests++;
    if (a_oe_n !== 1'b1 || a_le !== 1'b0 || a_data !== 8'h3C) begin
      fails++;
      $display("FAIL oe_k2: oe_n=%b le=%b data=%h expected 1 0 3C", a_oe_n, a_le, a_data);
    end
    step();
    step();
  endtask

  task automatic test_timing_b();
    logic [9:0] le_mask;
    int         rdy_at, n;
    le_mask = '0;
    rdy_at  = -1;
    n       = 0;
    b_in       = 8'h0F;
    b_in_valid = 1'b1;
    while (!b_in_ready && n < 20) begin
      step();
      n++;
    end
    step();
    b_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      le_mask[k] = b_le;
      if (b_in_ready && rdy_at < 0) rdy_at = k;
      step();
    end
    tests++;
    if (le_mask !== 10'b00_0001_1100) begin
      fails++;
      $display("FAIL b_le_window: mask=%b expected 0000011100", le_mask);
    end
    tests++;
    if (rdy_at != 6) begin
      fails++;
      $display("FAIL b_ready_back: k=%0d expected 6", rdy_at);
    end
    tests++;
    if (b_last !== 8'h0F) begin
      fails++;
      $display("FAIL b_last: last=%h expected 0F", b_last);
    end
  endtask

  task automatic test_skip();
    int p0;
    bit skip_on;
`ifdef PIPO_WRITER_SKIP_EN
    skip_on = 1'b1;
`else
    skip_on = 1'b0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    p0 = pulse_cnt;
    start_write_a(8'hAA, 1'b1);
    for (int k = 0; k < 3; k++) step();
    start_write_a(8'hAA, !skip_on);
    tests++;
    if (a_in_ready !== skip_on || a_busy !== !skip_on) begin
      fails++;
      $display("FAIL skip_ready: in_ready=%b busy=%b expected %b %b",
               a_in_ready, a_busy, skip_on, !skip_on);
    end
    for (int k = 0; k < 6; k++) step();
    tests++;
    if (pulse_cnt - p0 != (skip_on ? 1 : 2)) begin
      fails++;
      $display("FAIL skip_pulses: pulses=%0d expected %0d", pulse_cnt - p0, skip_on ? 1 : 2);
    end
    tests++;
    if (a_data !== 8'hAA || a_last !== 8'hAA) begin
      fails++;
      $display("FAIL skip_data: data=%h last=%h expected AA AA", a_data, a_last);
    end
  endtask

  initial begin
    rst        = 1'b1;
    a_in_valid = 1'b0; a_in = 8'h00; a_oe_en = 1'b0;
    b_in_valid = 1'b0; b_in = 8'h00; b_oe_en = 1'b0;
    test_reset();
    test_single_write();
    test_reset_mid_strobe();
    test_back_to_back();
    test_oe_toggle();
    test_timing_b();
    test_skip();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words never strobed, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
